// File: rtl/periferico_bin2bcd_pkg.sv
// periferico_bin2bcd_pkg: register map, FSM encoding and digit helper for the BCD converter
package periferico_bin2bcd_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NDIG_DEF  = 5;

    localparam logic [4:0] ADDR_VAL    = 5'h04;
    localparam logic [4:0] ADDR_START  = 5'h0C;
    localparam logic [4:0] ADDR_BCD_LO = 5'h10;
    localparam logic [4:0] ADDR_BCD_HI = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 when doubled
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/periferico_bin2bcd_if.sv
// periferico_bin2bcd_if: calculator peripheral bus (chip select, address, strobes, data)
interface periferico_bin2bcd_if;

    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_in;
    logic [15:0] d_out;

    modport master (output cs, addr, rd, wr, d_in, input d_out);
    modport slave  (input cs, addr, rd, wr, d_in, output d_out);

endinterface

// File: rtl/periferico_bin2bcd_core.sv
// periferico_bin2bcd_core: sequential double-dabble, one operand bit per clock
module periferico_bin2bcd_core
    import periferico_bin2bcd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]          state;
    logic [WIDTH-1:0]    sh;
    logic [4*NDIG-1:0]   acc;
    logic [4*NDIG-1:0]   adj;
    logic [4*NDIG-1:0]   acc_nxt;
    logic [CW-1:0]       cnt;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        assign adj[4*i +: 4] = add3(acc[4*i +: 4]);
    end

    // Corrected accumulator shifted left with the next operand bit entering at the bottom
    assign acc_nxt = {adj[4*NDIG-2:0], sh[WIDTH-1]};

    // FSM: accept a start outside SHIFT, run WIDTH shifts, publish the result only on the last one
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= S_IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else if (state != S_SHIFT) begin
            if (start) begin
                sh    <= bin;
                acc   <= '0;
                cnt   <= CW'(WIDTH - 1);
                busy  <= 1'b1;
                done  <= 1'b0;
                state <= S_SHIFT;
            end
        end else begin
            sh  <= {sh[WIDTH-2:0], 1'b0};
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                bcd   <= acc_nxt;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
            end
        end
    end

endmodule

// File: rtl/periferico_bin2bcd.sv
// periferico_bin2bcd: bus-mapped binary-to-BCD converter (VAL register, decode, read mux)
module periferico_bin2bcd
    import periferico_bin2bcd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic                 CLK,
    input  logic                 reset,
    periferico_bin2bcd_if.slave  bus
);

    logic [WIDTH-1:0]  val;
    logic [4*NDIG-1:0] bcd;
    logic              busy;
    logic              done;
    logic              start;
    logic              rd_hit;
    logic [15:0]       rd_data;

    assign start = bus.cs && bus.wr && (bus.addr == ADDR_START) && bus.d_in[0];

    periferico_bin2bcd_core #(.WIDTH(WIDTH), .NDIG(NDIG)) u_core (
        .CLK   (CLK),
        .reset (reset),
        .start (start),
        .bin   (val),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Operand register; writable while busy since the core keeps its own shift copy
    always_ff @(posedge CLK) begin
        if (!reset)
            val <= '0;
        else if (bus.cs && bus.wr && bus.addr == ADDR_VAL)
            val <= bus.d_in[WIDTH-1:0];
    end

    // Read decode; rd_hit flags mapped addresses so unmapped reads leave d_out alone
    always_comb begin
        rd_hit  = 1'b1;
        rd_data = '0;
        case (bus.addr)
            ADDR_VAL:    rd_data = 16'(val);
            ADDR_BCD_LO: rd_data = bcd[15:0];
            ADDR_BCD_HI: rd_data = 16'(bcd[4*NDIG-1:16]);
            ADDR_STATUS: rd_data = {14'b0, busy, done};
            default:     rd_hit  = 1'b0;
        endcase
    end

    // Registered read data, one cycle after the strobe
    always_ff @(posedge CLK) begin
        if (!reset)
            bus.d_out <= '0;
        else if (bus.cs && bus.rd && rd_hit)
            bus.d_out <= rd_data;
    end

endmodule

// File: tb/tb_periferico_bin2bcd.sv
// tb_periferico_bin2bcd: table, corner-sequence and randomized checks of the BCD converter
module tb_periferico_bin2bcd;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    periferico_bin2bcd_if bus();

    periferico_bin2bcd dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] val;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.d_in = d;
        @(negedge CLK);
        bus.cs = 1'b0; bus.wr = 1'b0; bus.d_in = '0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [15:0] d);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        @(negedge CLK);
        bus.cs = 1'b0; bus.rd = 1'b0;
        d = bus.d_out;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic convert(input logic [15:0] v);
        wr_reg(5'h04, v);
        wr_reg(5'h0C, 16'h0001);
        idle(16);
    endtask

    logic [15:0] r;
    logic [19:0] m;
    logic [15:0] v;
    int          k;

    initial begin
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;
        vecs[0] = '{16'd1234,  16'h1234, 16'h0000};
        vecs[1] = '{16'd0,     16'h0000, 16'h0000};
        vecs[2] = '{16'd65535, 16'h5535, 16'h0006};
        vecs[3] = '{16'd9999,  16'h9999, 16'h0000};
        vecs[4] = '{16'd10000, 16'h0000, 16'h0001};
        vecs[5] = '{16'd1,     16'h0001, 16'h0000};

        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        rd_reg(5'h18, r); chk("reset_status", r, 16'h0000);
        rd_reg(5'h10, r); chk("reset_lo", r, 16'h0000);
        rd_reg(5'h14, r); chk("reset_hi", r, 16'h0000);
        rd_reg(5'h04, r); chk("reset_val", r, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].val);
            rd_reg(5'h18, r); chk($sformatf("vec%0d_status", i), r, 16'h0001);
            rd_reg(5'h10, r); chk($sformatf("vec%0d_lo", i), r, vecs[i].lo);
            rd_reg(5'h14, r); chk($sformatf("vec%0d_hi", i), r, vecs[i].hi);
        end

        wr_reg(5'h04, 16'd321);
        wr_reg(5'h0C, 16'h0001);
        k = 0;
        for (int c = 1; c <= 30 && k == 0; c++) begin
            rd_reg(5'h18, r);
            if (r == 16'h0001) k = c;
        end
        chk("latency_read_edge", 16'(k), 16'd17);

        convert(16'd1234);
        wr_reg(5'h04, 16'd42);
        wr_reg(5'h0C, 16'h0001);
        idle(4);
        rd_reg(5'h18, r); chk("busy_status", r, 16'h0002);
        rd_reg(5'h10, r); chk("busy_old_lo", r, 16'h1234);
        wr_reg(5'h04, 16'd7);
        wr_reg(5'h0C, 16'h0001);
        idle(10);
        rd_reg(5'h18, r); chk("busy_done_status", r, 16'h0001);
        rd_reg(5'h10, r); chk("busy_final_lo", r, 16'h0042);
        rd_reg(5'h04, r); chk("busy_val_written", r, 16'd7);
        idle(20);
        rd_reg(5'h10, r); chk("no_queued_start", r, 16'h0042);

        wr_reg(5'h0C, 16'h0002);
        rd_reg(5'h18, r); chk("start_bit0_clear", r, 16'h0001);

        rd_reg(5'h18, r); chk("unmapped_pre", r, 16'h0001);
        rd_reg(5'h08, r); chk("unmapped_read_hold", r, 16'h0001);
        wr_reg(5'h08, 16'hBEEF);
        rd_reg(5'h04, r); chk("unmapped_write_val", r, 16'd7);

        wr_reg(5'h04, 16'd500);
        wr_reg(5'h0C, 16'h0001);
        idle(6);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        rd_reg(5'h18, r); chk("midreset_status", r, 16'h0000);
        rd_reg(5'h10, r); chk("midreset_lo", r, 16'h0000);
        idle(20);
        rd_reg(5'h18, r); chk("midreset_stays_idle", r, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom_range(0, 65535));
            m = to_bcd(int'(v));
            convert(v);
            rd_reg(5'h18, r); chk($sformatf("rnd%0d_status", i), r, 16'h0001);
            rd_reg(5'h10, r); chk($sformatf("rnd%0d_lo_v%0d", i, v), r, m[15:0]);
            rd_reg(5'h14, r); chk($sformatf("rnd%0d_hi_v%0d", i, v), r, {12'b0, m[19:16]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
